// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Sequences a PLL through reset, lock qualification, timeout/retry and
// loss-of-lock recovery. A clean downstream reset is released only after the
// PLL lock has been stable. Runs on the free-running reference clock.
//
// Ports:
//   clk       free-running reference clock (same source as PLL clkin1)
//   rst       asynchronous active-high reset
//   restart   synchronous single-cycle request to restart the sequence
//   pll_lock  PLL lock indication, asynchronous to clk
//   pll_rst   registered PLL reset, active-high
//   rst_out   registered downstream reset, active-high
//   locked    high only in RUN
//   fault     high only in FAULT
//   retry_cnt failed attempts since last success/restart
//   loss_cnt  loss-of-lock events in RUN, saturating at 255
//   state     00 RESET_PLL, 01 WAIT_LOCK, 10 RUN, 11 FAULT
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int GLITCH_CYCLES = 4,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       rst_out,
  output logic       locked,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [1:0] state
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int GW = $clog2(GLITCH_CYCLES) + 1;

  localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  localparam logic [1:0] S_RESET_PLL = 2'b00;
  localparam logic [1:0] S_WAIT_LOCK = 2'b01;
  localparam logic [1:0] S_RUN       = 2'b10;
  localparam logic [1:0] S_FAULT     = 2'b11;

  logic [1:0]    r_state;
  logic [RW-1:0] r_rst_cnt;
  logic [SW-1:0] r_stable_cnt;
  logic [TW-1:0] r_timeout_cnt;
  logic [GW-1:0] r_glitch_cnt;
  logic [3:0]    r_retry_cnt;
  logic [7:0]    r_loss_cnt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_pll_rst;
  logic          r_rst_out;
  logic          r_locked;
  logic          r_fault;

  logic [1:0]    w_state_nxt;
  logic [RW-1:0] w_rst_cnt_nxt;
  logic [SW-1:0] w_stable_cnt_nxt;
  logic [TW-1:0] w_timeout_cnt_nxt;
  logic [GW-1:0] w_glitch_cnt_nxt;
  logic [3:0]    w_retry_cnt_nxt;
  logic [7:0]    w_loss_cnt_nxt;
  logic          w_pll_rst_nxt;
  logic          w_rst_out_nxt;
  logic          w_locked_nxt;
  logic          w_fault_nxt;
  logic          w_lock_s;

  assign w_lock_s = r_sync2;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_lock;
      r_sync2 <= r_sync1;
    end
  end

  // State register: FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RESET_PLL;
      r_rst_cnt     <= '0;
      r_stable_cnt  <= '0;
      r_timeout_cnt <= '0;
      r_glitch_cnt  <= '0;
      r_retry_cnt   <= 4'd0;
      r_loss_cnt    <= 8'd0;
      r_pll_rst     <= 1'b1;
      r_rst_out     <= 1'b1;
      r_locked      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rst_cnt     <= w_rst_cnt_nxt;
      r_stable_cnt  <= w_stable_cnt_nxt;
      r_timeout_cnt <= w_timeout_cnt_nxt;
      r_glitch_cnt  <= w_glitch_cnt_nxt;
      r_retry_cnt   <= w_retry_cnt_nxt;
      r_loss_cnt    <= w_loss_cnt_nxt;
      r_pll_rst     <= w_pll_rst_nxt;
      r_rst_out     <= w_rst_out_nxt;
      r_locked      <= w_locked_nxt;
      r_fault       <= w_fault_nxt;
    end
  end

  // Next-state and counter logic; restart overrides every transition.
  always_comb begin
    w_state_nxt       = r_state;
    w_rst_cnt_nxt     = r_rst_cnt;
    w_stable_cnt_nxt  = r_stable_cnt;
    w_timeout_cnt_nxt = r_timeout_cnt;
    w_glitch_cnt_nxt  = r_glitch_cnt;
    w_retry_cnt_nxt   = r_retry_cnt;
    w_loss_cnt_nxt    = r_loss_cnt;
    if (restart) begin
      w_state_nxt       = S_RESET_PLL;
      w_rst_cnt_nxt     = '0;
      w_stable_cnt_nxt  = '0;
      w_timeout_cnt_nxt = '0;
      w_glitch_cnt_nxt  = '0;
      w_retry_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_rst_cnt == RST_LAST) begin
            w_state_nxt       = S_WAIT_LOCK;
            w_rst_cnt_nxt     = '0;
            w_stable_cnt_nxt  = '0;
            w_timeout_cnt_nxt = '0;
          end else begin
            w_rst_cnt_nxt = r_rst_cnt + RW'(1);
          end
        end
        S_WAIT_LOCK: begin
          // Stable qualification is checked first so it wins a tie with timeout.
          if (w_lock_s && (r_stable_cnt == STABLE_LAST)) begin
            w_state_nxt       = S_RUN;
            w_retry_cnt_nxt   = 4'd0;
            w_stable_cnt_nxt  = '0;
            w_timeout_cnt_nxt = '0;
            w_glitch_cnt_nxt  = '0;
          end else if (r_timeout_cnt == TO_LAST) begin
            w_stable_cnt_nxt  = '0;
            w_timeout_cnt_nxt = '0;
            w_rst_cnt_nxt     = '0;
            if (r_retry_cnt == RETRY_MAX) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt     = S_RESET_PLL;
              w_retry_cnt_nxt = r_retry_cnt + 4'd1;
            end
          end else begin
            w_timeout_cnt_nxt = r_timeout_cnt + TW'(1);
            if (w_lock_s) begin
              w_stable_cnt_nxt = r_stable_cnt + SW'(1);
            end else begin
              w_stable_cnt_nxt = '0;
            end
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            if (r_glitch_cnt == GLITCH_LAST) begin
              w_state_nxt      = S_RESET_PLL;
              w_glitch_cnt_nxt = '0;
              w_rst_cnt_nxt    = '0;
              if (r_loss_cnt != 8'hFF) begin
                w_loss_cnt_nxt = r_loss_cnt + 8'd1;
              end else begin
                w_loss_cnt_nxt = r_loss_cnt;
              end
            end else begin
              w_glitch_cnt_nxt = r_glitch_cnt + GW'(1);
            end
          end else begin
            w_glitch_cnt_nxt = '0;
          end
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
        end
      endcase
    end
  end

  // Output decode from the next state, so outputs move on the transition edge.
  always_comb begin
    w_pll_rst_nxt = 1'b1;
    w_rst_out_nxt = 1'b1;
    w_locked_nxt  = 1'b0;
    w_fault_nxt   = 1'b0;
    case (w_state_nxt)
      S_RESET_PLL: begin
        w_pll_rst_nxt = 1'b1;
      end
      S_WAIT_LOCK: begin
        w_pll_rst_nxt = 1'b0;
      end
      S_RUN: begin
        w_pll_rst_nxt = 1'b0;
        w_rst_out_nxt = 1'b0;
        w_locked_nxt  = 1'b1;
      end
      S_FAULT: begin
        w_fault_nxt = 1'b1;
      end
      default: begin
        w_pll_rst_nxt = 1'b1;
      end
    endcase
  end

  assign pll_rst   = r_pll_rst;
  assign rst_out   = r_rst_out;
  assign locked    = r_locked;
  assign fault     = r_fault;
  assign retry_cnt = r_retry_cnt;
  assign loss_cnt  = r_loss_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: table of timed vectors with a scoreboard
// queue, plus hand-written sequences for async reset and loss saturation.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       pll_lock;
  logic       pll_rst;
  logic       rst_out;
  logic       locked;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RST_CYCLES(4), .STABLE_CYCLES(8), .LOCK_TIMEOUT(32),
    .GLITCH_CYCLES(3), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .rst_out(rst_out), .locked(locked), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
  );

  typedef struct packed {
    logic [1:0] st;
    logic       prst;
    logic       rout;
    logic       lk;
    logic       flt;
    logic [3:0] rc;
    logic [7:0] lc;
  } out_t;

  // Apply lock/restart (restart for the first cycle only), advance n cycles,
  // then compare against exp.
  typedef struct {
    string name;
    int    n;
    logic  lock;
    logic  rs;
    out_t  exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_loss;

  // Expected outputs derived from the per-state output definitions.
  function automatic out_t mk(logic [1:0] st, logic [3:0] rc, logic [7:0] lc);
    out_t o;
    o.st   = st;
    o.prst = (st == 2'b00) || (st == 2'b11);
    o.rout = (st != 2'b10);
    o.lk   = (st == 2'b10);
    o.flt  = (st == 2'b11);
    o.rc   = rc;
    o.lc   = lc;
    return o;
  endfunction

  task automatic add(string name, int n, logic lock, logic rs,
                     logic [1:0] st, logic [3:0] rc, logic [7:0] lc);
    vec_t v;
    v.name = name;
    v.n    = n;
    v.lock = lock;
    v.rs   = rs;
    v.exp  = mk(st, rc, lc);
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name);
    out_t e;
    out_t a;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      a = {state, pll_rst, rst_out, locked, fault, retry_cnt, loss_cnt};
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%b prst=%b rout=%b lk=%b flt=%b rc=%0d lc=%0d, want st=%b prst=%b rout=%b lk=%b flt=%b rc=%0d lc=%0d",
                 name, a.st, a.prst, a.rout, a.lk, a.flt, a.rc, a.lc,
                 e.st, e.prst, e.rout, e.lk, e.flt, e.rc, e.lc);
      end
    end
  endtask

  task automatic wait_state(logic [1:0] target, int budget, string name);
    int k;
    k = 0;
    while ((state !== target) && (k < budget)) begin
      tick();
      k++;
    end
    if (state !== target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, state=%b want %b", name, state, target);
    end
  endtask

  initial begin
    rst      = 1'b1;
    restart  = 1'b0;
    pll_lock = 1'b0;

    // Nominal: the PLL acquires lock once its reset is released.
    add("nom_rst_hold",    3, 1'b0, 1'b0, 2'b00, 4'd0, 8'd0);
    add("nom_enter_wait",  1, 1'b0, 1'b0, 2'b01, 4'd0, 8'd0);
    add("nom_qualifying",  9, 1'b1, 1'b0, 2'b01, 4'd0, 8'd0);
    add("nom_run",         1, 1'b1, 1'b0, 2'b10, 4'd0, 8'd0);
    // Glitch filter: 2-cycle drop ignored, 3-cycle drop is a loss.
    add("gl2_during",      2, 1'b0, 1'b0, 2'b10, 4'd0, 8'd0);
    add("gl2_after",       4, 1'b1, 1'b0, 2'b10, 4'd0, 8'd0);
    add("gl3_during",      3, 1'b0, 1'b0, 2'b10, 4'd0, 8'd0);
    add("gl3_loss",        2, 1'b1, 1'b0, 2'b00, 4'd0, 8'd1);
    add("gl3_rst_hold",    3, 1'b1, 1'b0, 2'b00, 4'd0, 8'd1);
    add("gl3_wait",        1, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("gl3_qualifying",  7, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("gl3_relock",      1, 1'b1, 1'b0, 2'b10, 4'd0, 8'd1);
    // Unstable lock: one-cycle dropout after 6 high cycles.
    add("unst_restart",    1, 1'b0, 1'b1, 2'b00, 4'd0, 8'd1);
    add("unst_wait",       4, 1'b0, 1'b0, 2'b01, 4'd0, 8'd1);
    add("unst_high6",      6, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("unst_drop",       1, 1'b0, 1'b0, 2'b01, 4'd0, 8'd1);
    add("unst_no_early",   3, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("unst_almost",     6, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("unst_run",        1, 1'b1, 1'b0, 2'b10, 4'd0, 8'd1);
    // Retry to fault with lock never asserted.
    add("rt_restart",      1, 1'b0, 1'b1, 2'b00, 4'd0, 8'd1);
    add("rt_wait1",        4, 1'b0, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rt_to1_before",  31, 1'b0, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rt_to1",          1, 1'b0, 1'b0, 2'b00, 4'd1, 8'd1);
    add("rt_wait2",        4, 1'b0, 1'b0, 2'b01, 4'd1, 8'd1);
    add("rt_to2",         32, 1'b0, 1'b0, 2'b00, 4'd2, 8'd1);
    add("rt_wait3",        4, 1'b0, 1'b0, 2'b01, 4'd2, 8'd1);
    add("rt_to3_before",  31, 1'b0, 1'b0, 2'b01, 4'd2, 8'd1);
    add("rt_fault",        1, 1'b0, 1'b0, 2'b11, 4'd2, 8'd1);
    add("rt_fault_sticky", 1000, 1'b0, 1'b0, 2'b11, 4'd2, 8'd1);
    // Restart from FAULT, then nominal lock.
    add("rs_fault",        1, 1'b1, 1'b1, 2'b00, 4'd0, 8'd1);
    add("rs_f_rst_hold",   3, 1'b1, 1'b0, 2'b00, 4'd0, 8'd1);
    add("rs_f_wait",       1, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rs_f_qual",       7, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rs_f_run",        1, 1'b1, 1'b0, 2'b10, 4'd0, 8'd1);
    // Restart mid-WAIT_LOCK after one failed attempt.
    add("rs_w_restart0",   1, 1'b0, 1'b1, 2'b00, 4'd0, 8'd1);
    add("rs_w_wait1",      4, 1'b0, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rs_w_to1",       32, 1'b0, 1'b0, 2'b00, 4'd1, 8'd1);
    add("rs_w_wait2",      4, 1'b0, 1'b0, 2'b01, 4'd1, 8'd1);
    add("rs_w_mid",        5, 1'b0, 1'b0, 2'b01, 4'd1, 8'd1);
    add("rs_w_restart",    1, 1'b1, 1'b1, 2'b00, 4'd0, 8'd1);
    add("rs_w_rst_hold",   3, 1'b1, 1'b0, 2'b00, 4'd0, 8'd1);
    add("rs_w_wait",       1, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rs_w_qual",       7, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rs_w_run",        1, 1'b1, 1'b0, 2'b10, 4'd0, 8'd1);
    // Restart inside RESET_PLL restarts the reset count.
    add("rs_r_first",      1, 1'b1, 1'b1, 2'b00, 4'd0, 8'd1);
    add("rs_r_cnt2",       2, 1'b1, 1'b0, 2'b00, 4'd0, 8'd1);
    add("rs_r_again",      1, 1'b1, 1'b1, 2'b00, 4'd0, 8'd1);
    add("rs_r_held",       3, 1'b1, 1'b0, 2'b00, 4'd0, 8'd1);
    add("rs_r_wait",       1, 1'b1, 1'b0, 2'b01, 4'd0, 8'd1);
    add("rs_r_run",        8, 1'b1, 1'b0, 2'b10, 4'd0, 8'd1);

    tick();
    tick();
    exp_q.push_back(mk(2'b00, 4'd0, 8'd0));
    check("reset_values");
    rst = 1'b0;

    foreach (tbl[i]) begin
      pll_lock = tbl[i].lock;
      restart  = tbl[i].rs;
      exp_q.push_back(tbl[i].exp);
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        restart = 1'b0;
      end
      check(tbl[i].name);
    end

    // Asynchronous reset between clock edges while in RUN.
    #3;
    rst = 1'b1;
    #1;
    exp_q.push_back(mk(2'b00, 4'd0, 8'd0));
    check("async_rst");
    tick();
    tick();
    rst = 1'b0;

    // Force 257 losses; loss_cnt must saturate at 255.
    exp_loss = 8'd0;
    for (int i = 0; i < 257; i++) begin
      pll_lock = 1'b1;
      wait_state(2'b10, 100, "sat_run");
      pll_lock = 1'b0;
      exp_loss = (exp_loss == 8'hFF) ? 8'hFF : exp_loss + 8'd1;
      exp_q.push_back(mk(2'b00, 4'd0, exp_loss));
      wait_state(2'b00, 20, "sat_loss_wait");
      check("sat_loss");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
